uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
- UART receiver: the receive-side counterpart of the UART transmit path.
- Oversamples the serial RX_IN line by a runtime Prescale and recovers bits by majority-of-3 at mid-bit.
- Deserializes LSB-first frames, optionally checks parity, checks the stop bit, and presents a parallel word with a one-cycle valid pulse.
- Sits between the pad-side RX_IN synchronizer and the system register/FIFO write side.

Parameters:
DATA_WIDTH, 8, payload bits per frame
PRESCALE_W, 6, width of Prescale input

Ports:
CLK  in  1  system clock (oversampling clock)
RST  in  1  asynchronous active-low reset
RX_IN  in  1  serial line, idle high, already synchronized to CLK
PAR_EN  in  1  1 = frame carries a parity bit after data
PAR_TYP  in  1  0 = even parity, 1 = odd parity
Prescale  in  PRESCALE_W  oversampling ratio; 8, 16 or 32
P_DATA  out  DATA_WIDTH  received word, held until next good frame
data_valid  out  1  one-cycle pulse, good frame in P_DATA
par_err  out  1  one-cycle pulse, parity mismatch
stp_err  out  1  one-cycle pulse, stop bit sampled 0

Behaviour:
- Clock and reset: single clock CLK; reset RST is asynchronous, active-low.
- Reset: state=IDLE, counters=0, P_DATA=0, data_valid=0, par_err=0, stp_err=0.
- Reset mid-frame aborts the frame with no output pulse.
- Config latch: PAR_EN, PAR_TYP and Prescale are registered on start detection. Changes mid-frame are ignored until the next frame.
- Prescale handling: Prescale values other than 8, 16 or 32 are treated as 8.
- edge_cnt: counts 0..P-1 per bit, where P is the latched Prescale. It is 0 in the first cycle after leaving IDLE and wraps to 0 after P-1.
- bit_cnt: increments on each edge_cnt wrap.
- Sampling: RX_IN is captured at edge_cnt = P/2-1, P/2 and P/2+1. The sampled bit is the majority of the three and is valid from edge_cnt = P/2+2.
- States:
  - IDLE: RX_IN==0 -> START (this cycle is detection cycle 0). Otherwise stay.
  - START: at edge_cnt=P-1, sampled bit 0 -> DATA. Sampled bit 1 -> IDLE (glitch reject, no pulses).
  - DATA: at each edge_cnt=P-1, shift the sampled bit into the shift register, LSB first. After DATA_WIDTH bits -> PARITY if PAR_EN, else STOP.
  - PARITY: at edge_cnt=P-1, record mismatch. Expected bit = XOR(data) for even, ~XOR(data) for odd. Then -> STOP.
  - STOP: at edge_cnt=P-1, record sampled bit==0 as stop error. Then -> IDLE.
- Frame-end outputs, registered, appear in the first IDLE cycle after STOP:
  - par_err = parity mismatch (0 when PAR_EN=0).
  - stp_err = stop error.
  - data_valid = 1 only if both are 0; P_DATA is updated in the same cycle.
  - On any error, P_DATA is not updated.
  - All three outputs are 1-cycle pulses.
- Latency: data_valid asserts (P*(DATA_WIDTH+2+PAR_EN)+1) cycles after the detection cycle. Examples: P=8, 8N1 -> cycle 81; P=8 with parity -> cycle 89.
- Back-to-back frames: the first IDLE cycle (the pulse cycle) may already detect the next start bit.
- RX_IN stuck low after a stop error: re-detected as a start in IDLE. The glitch-reject path then handles it normally.

Decomposition:
- Package uart_rx_pkg:
  - state encoding (IDLE, START, DATA, PARITY, STOP)
  - PAR_EVEN=0 / PAR_ODD=1 constants
  - supported-prescale constants
- Sub-module uart_rx_sampler:
  - edge_cnt
  - 3-tap capture with majority vote
  - sample_valid strobe
- FSM, bit_cnt, shift register, parity/stop checks and output registers stay in uart_rx_core.

Test Plan:
1. P=8, PAR_EN=0, send 0xA5 8N1 -> data_valid pulse at cycle 81 after start detection, P_DATA=0xA5, par_err=stp_err=0.
2. P=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 0 -> P_DATA=0x3C, data_valid=1. Repeat with parity bit 1 -> par_err pulse, data_valid=0, P_DATA stays 0x3C.
3. P=32, PAR_EN=1, PAR_TYP=1, send 0xFF with stop bit 0 -> stp_err pulse, data_valid=0.
4. P=8, RX_IN low for 3 cycles then high -> START aborts to IDLE, no pulses. A following 0x5A frame is received correctly.
5. Single-cycle glitch on each data bit at edge P/2 (P=16), send 0x96 -> majority vote recovers P_DATA=0x96.
6. Two 0x12/0x34 frames back-to-back with no idle gap, plus RST low mid-second-frame -> first frame valid; outputs go to 0 immediately on reset; no pulse for the aborted frame.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: state encoding, parity
// selectors and the supported oversampling ratios.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    // Anything other than 16 or 32 falls back to 8x oversampling.
    function automatic logic [5:0] norm_prescale(input logic [31:0] p);
        if (p == 32'(PRESCALE_16)) begin
            return 6'(PRESCALE_16);
        end
        if (p == 32'(PRESCALE_32)) begin
            return 6'(PRESCALE_32);
        end
        return 6'(PRESCALE_8);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter with a 3-tap mid-bit capture and majority vote.
// sample_valid marks the last oversampling cycle of a bit, when sampled_bit is settled.
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       active,
    input  logic       RX_IN,
    input  logic [5:0] prescale,
    output logic       sampled_bit,
    output logic       sample_valid
);

    logic [4:0] edge_cnt;
    logic [2:0] taps;
    logic [4:0] half;
    logic       last_edge;

    assign half      = prescale[5:1];
    assign last_edge = (edge_cnt == 5'(prescale - 6'd1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            taps     <= '0;
        end else begin
            if (!active || last_edge) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + 5'd1;
            end
            if (active) begin
                if (edge_cnt == half - 5'd1) taps[0] <= RX_IN;
                if (edge_cnt == half)        taps[1] <= RX_IN;
                if (edge_cnt == half + 5'd1) taps[2] <= RX_IN;
            end
        end
    end

    assign sampled_bit  = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
    assign sample_valid = active & last_edge;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start detection, LSB-first deserialisation, parity/stop
// checks and single-cycle result pulses emitted on return to IDLE.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 3);

    uart_rx_state_e        state_q, state_d;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [5:0]            p_q;
    logic                  par_en_q, par_typ_q, par_bad_q;
    logic                  sampled_bit, sample_valid, start_det;

    assign start_det = (state_q == ST_IDLE) && !RX_IN;

    uart_rx_sampler u_sampler (
        .CLK          (CLK),
        .RST          (RST),
        .active       (state_q != ST_IDLE),
        .RX_IN        (RX_IN),
        .prescale     (p_q),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!RX_IN) state_d = ST_START;
            ST_START:  if (sample_valid) state_d = sampled_bit ? ST_IDLE : ST_DATA;
            ST_DATA:   if (sample_valid && bit_cnt_q == BIT_W'(DATA_WIDTH))
                           state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (sample_valid) state_d = ST_STOP;
            ST_STOP:   if (sample_valid) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // bit_cnt reads 1..DATA_WIDTH while data bits are in flight (start bit is 0).
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            p_q        <= 6'(PRESCALE_8);
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            par_bad_q  <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (state_q == ST_IDLE) begin
                bit_cnt_q <= '0;
            end else if (sample_valid) begin
                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
            if (start_det) begin
                p_q       <= norm_prescale(32'(Prescale));
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                par_bad_q <= 1'b0;
            end
            if (sample_valid) begin
                case (state_q)
                    ST_DATA:   shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    ST_PARITY: par_bad_q <= (sampled_bit != ((^shift_q) ^ par_typ_q));
                    ST_STOP: begin
                        par_err <= par_bad_q;
                        stp_err <= !sampled_bit;
                        if (!par_bad_q && sampled_bit) begin
                            data_valid <= 1'b1;
                            P_DATA     <= shift_q;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
